// File: rtl/delay_chain_pkg.sv
// Shared types and helpers for the handshake delay chain.
// Stage record at the default width, plus the occupancy popcount.
package delay_chain_pkg;

    localparam int DW_DEFAULT  = 8;
    localparam int LEN_DEFAULT = 5;
    localparam int LEN_MAX     = 64;

    typedef struct packed {
        logic                  valid;
        logic [DW_DEFAULT-1:0] data;
    } stage_t;

    // Callers zero-extend their valid vector to LEN_MAX bits.
    function automatic int unsigned popcount_f(input logic [LEN_MAX-1:0] bits);
        int unsigned n;
        n = 0;
        for (int i = 0; i < LEN_MAX; i++) begin
            n = n + int'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/handshake_pipe_stage.sv
// One valid/ready register slice. It accepts from upstream whenever it is
// empty or its own word is leaving, so bubbles collapse under backpressure.
module handshake_pipe_stage
    import delay_chain_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          up_valid,
    input  logic [DW-1:0] up_data,
    input  logic          dn_ready,
    output logic          rdy,
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    assign rdy   = !valid_q || dn_ready;
    assign valid = valid_q;
    assign data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            // Data is left in place; only the valid bits are cleared.
            valid_d = 1'b0;
        end else if (rdy) begin
            valid_d = up_valid;
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/handshake_delay_chain.sv
// Fixed-depth delay chain with valid/ready flow control and bubble collapse.
// LEN stage slices share a combinational ready chain rooted at out_ready.
module handshake_delay_chain
    import delay_chain_pkg::*;
#(
    parameter  int DW  = 8,
    parameter  int LEN = 5,
    localparam int CW  = $clog2(LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] count
);

    if (LEN < 1) begin : g_len_too_small
        $fatal(1, "handshake_delay_chain: LEN must be at least 1");
    end
    if (LEN > LEN_MAX) begin : g_len_too_large
        $fatal(1, "handshake_delay_chain: LEN exceeds LEN_MAX");
    end

    logic [LEN:0]   rdy_w;
    logic [LEN-1:0] valid_w;
    logic [DW-1:0]  data_w [LEN];
    logic [LEN-1:0] src_valid_w;
    logic [DW-1:0]  src_data_w [LEN];
    logic [LEN-1:0] next_valid_w;

    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;

    assign rdy_w[LEN] = out_ready;
    assign in_ready   = rdy_w[0] && !flush;
    assign out_valid  = valid_w[LEN-1];
    assign out_data   = data_w[LEN-1];
    assign count      = count_q;

    genvar gi;
    for (gi = 0; gi < LEN; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign src_valid_w[gi] = in_valid;
            assign src_data_w[gi]  = in_data;
        end else begin : g_body
            assign src_valid_w[gi] = valid_w[gi-1];
            assign src_data_w[gi]  = data_w[gi-1];
        end

        handshake_pipe_stage #(
            .DW (DW)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_valid (src_valid_w[gi]),
            .up_data  (src_data_w[gi]),
            .dn_ready (rdy_w[gi+1]),
            .rdy      (rdy_w[gi]),
            .valid    (valid_w[gi]),
            .data     (data_w[gi])
        );
    end

    // Mirror of each slice's valid update, so count tracks the state after the edge.
    always_comb begin
        next_valid_w = valid_w;
        for (int k = 0; k < LEN; k++) begin
            if (flush) begin
                next_valid_w[k] = 1'b0;
            end else if (rdy_w[k]) begin
                next_valid_w[k] = src_valid_w[k];
            end
        end
    end

    always_comb begin
        count_d = CW'(popcount_f(LEN_MAX'(next_valid_w)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: doc/handshake_delay_chain.md
Name: handshake_delay_chain

Overview:
- Fixed-depth delay chain with valid/ready flow control. It is the consumer-facing counterpart of the free-running delay chain.
- Data enters at one end and leaves LEN cycles later when the pipe is unstalled.
- A downstream consumer can apply backpressure. Stalled data is held, never dropped.
- Bubbles collapse, so a stall only blocks upstream stages that are full. Used wherever a delayed stream feeds a sink that cannot always accept.

Parameters:
- DW, 8: data width in bits.
- LEN, 5: number of register stages. Elaboration fails (fatal assertion) if LEN < 1.
- CW, $clog2(LEN+1): width of the occupancy count. Derived; not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all stage valids.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  chain can accept this cycle.
- in_data  input  DW  input word.
- out_valid  output  1  last stage holds a word.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DW  output word (stage LEN-1 register).
- count  output  CW  number of valid stages.

Behaviour:
- Stages are numbered 0..LEN-1. Stage k holds v[k] and d[k]. Stage 0 is fed from in_*. Stage LEN-1 drives out_*.
- Ready chain: rdy[LEN] = out_ready; rdy[k] = !v[k] || rdy[k+1]; in_ready = rdy[0] && !flush. The ready path is purely combinational; in_ready never depends on in_valid.
- Stage k (k ≥ 1) loads when rdy[k]:
  - v[k] <= v[k-1]
  - d[k] <= d[k-1]
  - Data loads only when v[k-1]=1, so d[k] holds otherwise.
- Stage 0 uses the same rule with in_valid/in_data as source.
- Stage update when !rdy[k]: hold v[k] and d[k].
- Transfers: a transfer in occurs when in_valid && in_ready; a transfer out occurs when out_valid && out_ready.
- Latency:
  - With out_ready held high, a word accepted at edge N appears on out_data with out_valid=1 after edge N+LEN-1, and transfers out at edge N+LEN.
  - Throughput is 1 word per cycle.
- Ordering: strict FIFO. There is no duplication or loss under any out_ready pattern.
- Capacity: LEN words. When all v[k]=1 and out_ready=0, in_ready=0.
- Full-and-draining: when all valid and out_ready=1, in_ready=1 in the same cycle. The full chain shifts.
- Bubble collapse: if v[j]=0 for some j, stages < j still advance while out_ready=0.
- count: registered popcount of next-state valids. It equals the number of v[k] set after each edge. count = LEN exactly when full.
- flush:
  - On an edge with flush=1, all v[k] <= 0 and count <= 0. d[k] is unchanged.
  - flush beats a simultaneous in_valid: in_ready=0 that cycle, so no word is accepted.
  - out_valid and out_data still reflect pre-flush state in that cycle, so a downstream handshake that cycle counts as a transfer.
- Reset (rst_n=0, asynchronous assert):
  - All v[k]=0 and d[k]='0. Therefore out_valid=0, out_data='0, count=0.
  - in_ready follows the combinational equation, so it is 1 with flush=0.
  - Reset mid-stream discards all held words. Deassertion takes effect at the next edge.
- Protocol expectations on neighbours (checked by the bench with assertions, not enforced by RTL): once asserted, in_valid holds and in_data stays stable until accepted. The block guarantees the same for out_valid/out_data.

Decomposition:
- Package delay_chain_pkg holds:
  - a parameterised stage struct {logic valid; logic [DW-1:0] data}, as a typedef inside a parameterised class or a fixed-width default;
  - a function popcount_f for count.
- Sub-module handshake_pipe_stage: one register slice with ports clk, rst_n, flush, up_valid, up_data, dn_ready, rdy, valid, data. The top generate-loops LEN instances and wires the ready chain.

Test Plan:
- Reset then stream, LEN=5, DW=8: out_ready=1; send 0x01..0x0A on consecutive cycles -> 0x01 on out_data with out_valid at the 5th edge after acceptance; the 10 words exit back-to-back in order; count steady at 5.
- Full stall: out_ready=0; offer 7 words -> in_ready drops after 5 accepted; count=5; out_data=0x01 held stable. Raise out_ready -> remaining words drain in order with no gap.
- Bubble collapse: send 0x11, idle 3 cycles, send 0x22 with out_ready=0 -> 0x22 advances until adjacent to 0x11; count=2; in_ready stays 1.
- Flush with simultaneous in_valid (in_data=0x55) while 3 words are held -> next cycle count=0, out_valid=0; 0x55 never appears at output.
- Async reset mid-stream: assert rst_n=0 between edges with 4 words held -> out_valid=0 and count=0 immediately, before the next edge. After release, the stream resumes from new input only.
- Random soak: 2000 cycles with random in_valid and out_ready (50%) against a scoreboard queue -> every sent word is received exactly once, in order; stable-while-stalled assertions pass.
